// File: rtl/sigmoid_req_arbiter_pkg.sv
// Shared types and constants for the sigmoid pipeline requester arbiter.
// bf16 constants, pipeline latency and the in-flight tag type.
package sigmoid_req_arbiter_pkg;

   localparam logic [15:0] BF16_ZERO = 16'h0000;
   localparam logic [15:0] BF16_HALF = 16'h3F00;
   localparam logic [15:0] BF16_ONE  = 16'h3F80;

   localparam int unsigned SIGMOID_PIPE_LAT = 5;

   // Wide enough for the largest supported requester count (8).
   localparam int unsigned SIGMOID_TAG_ID_W = 3;

   typedef struct packed {
      logic                        v;
      logic [SIGMOID_TAG_ID_W-1:0] id;
   } sigmoid_tag_t;

endpackage

// File: rtl/sigmoid_req_arbiter_if.sv
// Requester, pipeline and response signals of sigmoid_req_arbiter.
// SIGMOID_ARB_PERF_EN adds the performance counter outputs.
interface sigmoid_req_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*16-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  flush;
   logic                  idle;
   logic                  pipe_valid_in;
   logic [15:0]           pipe_data_in;
   logic                  pipe_valid_out;
   logic [15:0]           pipe_data_out;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [15:0]           rsp_data;
   logic                  tag_err;
`ifdef SIGMOID_ARB_PERF_EN
   logic [NUM_REQ*32-1:0] perf_issue_cnt;
   logic [31:0]           perf_busy_cnt;
`endif

   modport slave (
      input  req_valid, req_data, flush, pipe_valid_out, pipe_data_out,
      output req_ready, idle, pipe_valid_in, pipe_data_in, rsp_valid, rsp_data, tag_err
`ifdef SIGMOID_ARB_PERF_EN
      , output perf_issue_cnt, perf_busy_cnt
`endif
   );

   modport master (
      output req_valid, req_data, flush, pipe_valid_out, pipe_data_out,
      input  req_ready, idle, pipe_valid_in, pipe_data_in, rsp_valid, rsp_data, tag_err
`ifdef SIGMOID_ARB_PERF_EN
      , input perf_issue_cnt, perf_busy_cnt
`endif
   );

endinterface

// File: rtl/sigmoid_req_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: scans req upward from ptr, wrapping,
// and returns a one-hot grant plus its index.
module sigmoid_req_arbiter_rr_arbiter #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_idx
);

   logic            found;
   logic [ID_W-1:0] cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sigmoid_req_arbiter.sv
// Shares one pipelined sigmoid unit among NUM_REQ requesters; tags each op with its
// owner and steers results back. SIGMOID_ARB_PERF_EN adds issue/busy counters.
module sigmoid_req_arbiter
   import sigmoid_req_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned PIPE_LAT = SIGMOID_PIPE_LAT
) (
   input logic                  clk,
   input logic                  rst_n,
   sigmoid_req_arbiter_if.slave bus
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] req_masked;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic               issue;
   logic [15:0]        issue_data;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

   sigmoid_tag_t       tag_q [PIPE_LAT];
   sigmoid_tag_t       tag_last;
   logic               tag_empty;

   logic [NUM_REQ-1:0] rsp_valid_d, rsp_valid_q;
   logic [15:0]        rsp_data_q;
   logic               tag_err_q;

   // Reset masks the grant too, so req_ready reads 0 while rst_n is low.
   assign req_masked = bus.req_valid & {NUM_REQ{~bus.flush & rst_n}};

   sigmoid_req_arbiter_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req     (req_masked),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign issue = |gnt;

   always_comb begin
      issue_data = BF16_ZERO;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) issue_data = bus.req_data[16*i +: 16];
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (issue) rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
   end

   assign tag_last = tag_q[PIPE_LAT-1];

   always_comb begin
      tag_empty = 1'b1;
      for (int k = 0; k < PIPE_LAT; k++) begin
         if (tag_q[k].v) tag_empty = 1'b0;
      end
   end

   always_comb begin
      rsp_valid_d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid_d[i] = tag_last.v & bus.pipe_valid_out &
                          (tag_last.id == SIGMOID_TAG_ID_W'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         tag_err_q   <= 1'b0;
         for (int k = 0; k < PIPE_LAT; k++) tag_q[k] <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         rsp_valid_q <= rsp_valid_d;
         if (|rsp_valid_d) rsp_data_q <= bus.pipe_data_out;
         tag_err_q   <= tag_err_q | (tag_last.v != bus.pipe_valid_out);
         tag_q[0]    <= {issue, SIGMOID_TAG_ID_W'(gnt_idx)};
         for (int k = 1; k < PIPE_LAT; k++) tag_q[k] <= tag_q[k-1];
      end
   end

   assign bus.req_ready     = gnt;
   assign bus.pipe_valid_in = issue;
   assign bus.pipe_data_in  = issue_data;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_data      = rsp_data_q;
   assign bus.tag_err       = tag_err_q;
   assign bus.idle          = rst_n & tag_empty & (bus.flush | ~|bus.req_valid);

`ifdef SIGMOID_ARB_PERF_EN
   logic [NUM_REQ*32-1:0] issue_cnt_q;
   logic [31:0]           busy_cnt_q;

   // The issue cycle counts as busy, so N back-to-back ops give N+PIPE_LAT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_cnt_q <= '0;
         busy_cnt_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) issue_cnt_q[32*i +: 32] <= issue_cnt_q[32*i +: 32] + 32'd1;
         end
         if (issue || !tag_empty) busy_cnt_q <= busy_cnt_q + 32'd1;
      end
   end

   assign bus.perf_issue_cnt = issue_cnt_q;
   assign bus.perf_busy_cnt  = busy_cnt_q;
`endif

endmodule
